// File: rtl/key_exp_stream_if.sv
// -----------------------------------------------------------------------------
// key_exp_stream_if
// Round-key beat stream between the key expander (master) and the sink that
// stores the schedule (slave).
//   wr       : beat valid (master -> slave)
//   wr_ready : sink accepts the beat; a transfer happens on any rising edge
//              with wr && wr_ready (slave -> master)
//   wr_addr  : beat index (master -> slave)
//   wr_data  : WR_WIDTH/32 schedule words, lowest-index word in the MSBs
// -----------------------------------------------------------------------------
interface key_exp_stream_if #(
    parameter int WR_WIDTH = 64,
    parameter int ADDR_W   = 6
);
    logic                wr;
    logic                wr_ready;
    logic [ADDR_W-1:0]   wr_addr;
    logic [WR_WIDTH-1:0] wr_data;

    modport master (output wr, output wr_addr, output wr_data, input wr_ready);
    modport slave  (input wr, input wr_addr, input wr_data, output wr_ready);
endinterface

// File: rtl/key_exp_stream.sv
// -----------------------------------------------------------------------------
// key_exp_stream
// Streaming AES key expander (AES-128/192/256).  One schedule word is produced
// per clock; words that need SubWord take one extra cycle through a registered
// S-box stage.  Words are packed into WR_WIDTH-bit beats and handed to the sink
// over a valid/ready stream.
//
// Ports
//   clk        : clock, rising edge
//   reset_n    : asynchronous active-low reset
//   key_start  : one-cycle request to expand key_in (key_mode/key_in sampled)
//   key_mode   : 00 AES-128, 01 AES-192, 10 AES-256, 11 rejected
//   key_in     : cipher key, left aligned, word 0 in [255:224]
//   key_dec    : (only with KEY_EXP_STREAM_DEC_ORDER_EN) descending beat address
//   wr_if      : beat stream master (wr, wr_ready, wr_addr, wr_data)
//   busy       : expansion in progress
//   key_ready  : full schedule delivered; held until the next key_start
//   key_err    : one-cycle pulse when key_start carries key_mode 11
//
// Optional feature macro: KEY_EXP_STREAM_DEC_ORDER_EN (adds key_dec input).
// -----------------------------------------------------------------------------
module key_exp_stream #(
    parameter int WR_WIDTH = 64,
    parameter int ADDR_W   = 6
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    key_start,
    input  logic [1:0]              key_mode,
    input  logic [255:0]            key_in,
`ifdef KEY_EXP_STREAM_DEC_ORDER_EN
    input  logic                    key_dec,
`endif
    key_exp_stream_if.master        wr_if,
    output logic                    busy,
    output logic                    key_ready,
    output logic                    key_err
);

    localparam int WPB = WR_WIDTH / 32;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_GEN  = 2'd1;
    localparam logic [1:0] ST_SUB  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    // GF(2^8) multiply modulo x^8+x^4+x^3+x+1
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // AES S-box: multiplicative inverse (x^254) followed by the affine map
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = x;
        inv = 8'h01;
        for (int k = 1; k < 8; k++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    logic [1:0]          state_r;
    logic [3:0]          nk_r;
    logic [5:0]          nw_r;
    logic [5:0]          nbeats_r;
    logic [5:0]          word_idx_r;
    logic [2:0]          kmod_r;
    logic [5:0]          beat_cnt_r;
    logic [7:0]          rcon_r;
    logic [31:0]         sub_r;
    logic [31:0]         key_w_r [8];
    logic [31:0]         hist_r [8];      // hist_r[0] = w[i-1], hist_r[k] = w[i-1-k]
    logic [WR_WIDTH-1:0] beat_buf_r;
    logic                dec_r;
    logic                wr_r;
    logic [ADDR_W-1:0]   wr_addr_r;
    logic [WR_WIDTH-1:0] wr_data_r;
    logic                busy_r;
    logic                key_ready_r;
    logic                key_err_r;

    logic                dec_in_s;
    logic                mode_ok_s;
    logic [3:0]          nk_in_s;
    logic [5:0]          nw_in_s;
    logic [5:0]          nbeats_in_s;
    logic                stall_s;
    logic                xfer_s;
    logic                final_xfer_s;
    logic                gen_left_s;
    logic                rot_s;
    logic                need_sub_s;
    logic [31:0]         hist_far_s;
    logic [31:0]         sub_word_s;
    logic                produce_s;
    logic                enter_sub_s;
    logic [31:0]         word_s;
    logic                beat_end_s;
    logic [WR_WIDTH-1:0] beat_next_s;

`ifdef KEY_EXP_STREAM_DEC_ORDER_EN
    assign dec_in_s = key_dec;
`else
    assign dec_in_s = 1'b0;
`endif

    assign mode_ok_s    = (key_mode != 2'b11);
    assign stall_s      = wr_r && !wr_if.wr_ready;
    assign xfer_s       = wr_r && wr_if.wr_ready;
    assign final_xfer_s = xfer_s && (beat_cnt_r == (nbeats_r - 6'd1));
    assign gen_left_s   = (word_idx_r < nw_r);
    assign rot_s        = (kmod_r == 3'd0);
    // Key words themselves never go through the S-box
    assign need_sub_s   = (word_idx_r >= {2'b00, nk_r}) &&
                          (rot_s || ((nk_r == 4'd8) && (kmod_r == 3'd4)));
    assign hist_far_s   = hist_r[3'(nk_r - 4'd1)];
    assign sub_word_s   = sub_word(rot_s ? {hist_r[0][23:0], hist_r[0][31:24]} : hist_r[0]);
    assign beat_end_s   = ((word_idx_r & 6'(WPB - 1)) == 6'(WPB - 1));
    assign beat_next_s  = (beat_buf_r << 6'd32) | WR_WIDTH'(word_s);

    // Schedule geometry for the mode presented with key_start
    always_comb begin
        case (key_mode)
            2'b00: begin nk_in_s = 4'd4; nw_in_s = 6'd44; end
            2'b01: begin nk_in_s = 4'd6; nw_in_s = 6'd52; end
            2'b10: begin nk_in_s = 4'd8; nw_in_s = 6'd60; end
            default: begin nk_in_s = 4'd4; nw_in_s = 6'd44; end
        endcase
        nbeats_in_s = 6'(32'(nw_in_s) / WPB);
    end

    // Word generator: decide whether this edge produces a word or enters SUB
    always_comb begin
        produce_s   = 1'b0;
        enter_sub_s = 1'b0;
        word_s      = 32'h0000_0000;
        if ((state_r == ST_GEN) && gen_left_s && !stall_s) begin
            if (need_sub_s) begin
                enter_sub_s = 1'b1;
            end else begin
                produce_s = 1'b1;
                if (word_idx_r < {2'b00, nk_r}) begin
                    word_s = key_w_r[word_idx_r[2:0]];
                end else begin
                    word_s = hist_far_s ^ hist_r[0];
                end
            end
        end else if ((state_r == ST_SUB) && !stall_s) begin
            produce_s = 1'b1;
            word_s    = hist_far_s ^ sub_r;
        end else begin
            produce_s = 1'b0;
        end
    end

    // Control, history, beat packing and output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= ST_IDLE;
            nk_r        <= 4'd4;
            nw_r        <= 6'd0;
            nbeats_r    <= 6'd0;
            word_idx_r  <= 6'd0;
            kmod_r      <= 3'd0;
            beat_cnt_r  <= 6'd0;
            rcon_r      <= 8'h01;
            sub_r       <= 32'h0000_0000;
            beat_buf_r  <= '0;
            dec_r       <= 1'b0;
            wr_r        <= 1'b0;
            wr_addr_r   <= '0;
            wr_data_r   <= '0;
            busy_r      <= 1'b0;
            key_ready_r <= 1'b0;
            key_err_r   <= 1'b0;
            for (int k = 0; k < 8; k++) begin
                key_w_r[k] <= 32'h0000_0000;
                hist_r[k]  <= 32'h0000_0000;
            end
        end else if (key_start) begin
            // A new request always wins, aborting any expansion in flight
            wr_r        <= 1'b0;
            key_ready_r <= 1'b0;
            if (mode_ok_s) begin
                state_r    <= ST_GEN;
                busy_r     <= 1'b1;
                key_err_r  <= 1'b0;
                nk_r       <= nk_in_s;
                nw_r       <= nw_in_s;
                nbeats_r   <= nbeats_in_s;
                word_idx_r <= 6'd0;
                kmod_r     <= 3'd0;
                beat_cnt_r <= 6'd0;
                rcon_r     <= 8'h01;
                dec_r      <= dec_in_s;
                wr_addr_r  <= dec_in_s ? ADDR_W'(nbeats_in_s - 6'd1) : '0;
                for (int k = 0; k < 8; k++) begin
                    key_w_r[k] <= key_in[255 - 32*k -: 32];
                end
            end else begin
                state_r   <= ST_IDLE;
                busy_r    <= 1'b0;
                key_err_r <= 1'b1;
                wr_addr_r <= '0;
            end
        end else begin
            key_err_r <= 1'b0;

            if (xfer_s) begin
                wr_r       <= 1'b0;
                beat_cnt_r <= beat_cnt_r + 6'd1;
                wr_addr_r  <= dec_r ? (wr_addr_r - ADDR_W'(1)) : (wr_addr_r + ADDR_W'(1));
                if (final_xfer_s) begin
                    state_r     <= ST_DONE;
                    busy_r      <= 1'b0;
                    key_ready_r <= 1'b1;
                end
            end

            if (enter_sub_s) begin
                sub_r   <= sub_word_s ^ (rot_s ? {rcon_r, 24'h00_0000} : 32'h0000_0000);
                state_r <= ST_SUB;
                if (rot_s) begin
                    rcon_r <= {rcon_r[6:0], 1'b0} ^ (rcon_r[7] ? 8'h1b : 8'h00);
                end
            end

            if (produce_s) begin
                state_r    <= ST_GEN;
                word_idx_r <= word_idx_r + 6'd1;
                kmod_r     <= (kmod_r == 3'(nk_r - 4'd1)) ? 3'd0 : (kmod_r + 3'd1);
                hist_r[0]  <= word_s;
                for (int k = 1; k < 8; k++) begin
                    hist_r[k] <= hist_r[k-1];
                end
                beat_buf_r <= beat_next_s;
                if (beat_end_s) begin
                    wr_r      <= 1'b1;
                    wr_data_r <= beat_next_s;
                end
            end
        end
    end

    assign wr_if.wr      = wr_r;
    assign wr_if.wr_addr = wr_addr_r;
    assign wr_if.wr_data = wr_data_r;
    assign busy          = busy_r;
    assign key_ready     = key_ready_r;
    assign key_err       = key_err_r;

endmodule

// File: tb/tb_key_exp_stream.sv
// -----------------------------------------------------------------------------
// tb_key_exp_stream
// Self-checking bench for key_exp_stream (WR_WIDTH=64).  A reference model
// computes the AES key schedule directly from the FIPS-197 rules using a
// log/antilog-table S-box; every transferred beat is compared with it, along
// with known FIPS-197 words, completion timing, stall behaviour, abort,
// illegal mode and reset.
// -----------------------------------------------------------------------------
module tb_key_exp_stream;
    localparam int WR_WIDTH = 64;
    localparam int ADDR_W   = 6;
    localparam int WPB      = WR_WIDTH / 32;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         key_start = 1'b0;
    logic [1:0]   key_mode = 2'b00;
    logic [255:0] key_in = '0;
    logic         busy;
    logic         key_ready;
    logic         key_err;
`ifdef KEY_EXP_STREAM_DEC_ORDER_EN
    logic         key_dec = 1'b0;
`endif

    key_exp_stream_if #(.WR_WIDTH(WR_WIDTH), .ADDR_W(ADDR_W)) wr_if ();

    key_exp_stream #(.WR_WIDTH(WR_WIDTH), .ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .key_start (key_start),
        .key_mode  (key_mode),
        .key_in    (key_in),
`ifdef KEY_EXP_STREAM_DEC_ORDER_EN
        .key_dec   (key_dec),
`endif
        .wr_if     (wr_if.master),
        .busy      (busy),
        .key_ready (key_ready),
        .key_err   (key_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0]          sbox_t [256];
    logic [7:0]          rcon_tab [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                           8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
    logic [31:0]         mw [60];
    int                  m_nw;
    logic [WR_WIDTH-1:0] rx [64];
    int                  rx_n;
    bit                  cur_dec = 1'b0;

    task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] xt(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    // S-box from exp/log tables of generator 3, then the bitwise affine map
    task automatic build_sbox();
        logic [7:0] e [256];
        int         lg [256];
        logic [7:0] x, inv, s, c;
        c = 8'h63;
        x = 8'h01;
        for (int k = 0; k < 255; k++) begin
            e[k]  = x;
            lg[x] = k;
            x     = x ^ xt(x);
        end
        sbox_t[0] = 8'h63;
        for (int v = 1; v < 256; v++) begin
            inv = e[(255 - lg[v]) % 255];
            for (int b = 0; b < 8; b++)
                s[b] = inv[b] ^ inv[(b+4)%8] ^ inv[(b+5)%8] ^ inv[(b+6)%8] ^ inv[(b+7)%8] ^ c[b];
            sbox_t[v] = s;
        end
    endtask

    function automatic logic [31:0] subw(input logic [31:0] w);
        return {sbox_t[w[31:24]], sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]]};
    endfunction

    task automatic build_model(input logic [1:0] mode, input logic [255:0] key);
        logic [31:0] t;
        int          nk;
        nk   = (mode == 2'b00) ? 4 : (mode == 2'b01) ? 6 : 8;
        m_nw = 4 * (nk + 7);
        for (int i = 0; i < m_nw; i++) begin
            if (i < nk) begin
                mw[i] = key[255 - 32*i -: 32];
            end else begin
                t = mw[i-1];
                if (i % nk == 0) begin
                    t = subw({t[23:0], t[31:24]});
                    t[31:24] = t[31:24] ^ rcon_tab[i/nk - 1];
                end else if (nk > 6 && i % nk == 4) begin
                    t = subw(t);
                end
                mw[i] = mw[i-nk] ^ t;
            end
        end
    endtask

    function automatic logic [WR_WIDTH-1:0] model_beat(input int b);
        logic [WR_WIDTH-1:0] r;
        r = '0;
        for (int k = 0; k < WPB; k++) r = (r << 32) | WR_WIDTH'(mw[b*WPB + k]);
        return r;
    endfunction

    task automatic start_key(input logic [1:0] mode, input logic [255:0] key, input bit dec);
        @(negedge clk);
        key_start       = 1'b1;
        key_mode        = mode;
        key_in          = key;
        wr_if.wr_ready  = 1'b0;
        cur_dec         = dec;
`ifdef KEY_EXP_STREAM_DEC_ORDER_EN
        key_dec         = dec;
`endif
        @(posedge clk);
        #1;
        key_start = 1'b0;
        key_mode  = 2'($urandom);
        key_in    = {8{$urandom}};
    endtask

    // ready_mode: 0 = always ready, 1 = 3 on / 3 off, 2 = random
    task automatic run_sched(input int ready_mode, input int stop_after, output int final_edge);
        int                  edge_n;
        int                  nb;
        bit                  holding;
        logic [WR_WIDTH-1:0] held;
        edge_n     = 0;
        nb         = m_nw / WPB;
        holding    = 1'b0;
        held       = '0;
        rx_n       = 0;
        final_edge = -1;
        while (rx_n < nb && rx_n < stop_after && edge_n < 400) begin
            @(negedge clk);
            case (ready_mode)
                0:       wr_if.wr_ready = 1'b1;
                1:       wr_if.wr_ready = ((edge_n / 3) % 2 == 0);
                default: wr_if.wr_ready = 1'($urandom_range(0, 1));
            endcase
            #1;
            edge_n++;
            if (holding) begin
                check_val("stall_wr", wr_if.wr, 1'b1);
                check_val("stall_data", wr_if.wr_data, held);
            end
            holding = 1'b0;
            if (wr_if.wr && wr_if.wr_ready) begin
                check_val("beat_addr", wr_if.wr_addr, cur_dec ? (nb - 1 - rx_n) : rx_n);
                check_val("beat_data", wr_if.wr_data, model_beat(rx_n));
                rx[rx_n] = wr_if.wr_data;
                rx_n++;
                if (rx_n == nb) final_edge = edge_n;
            end else if (wr_if.wr) begin
                held    = wr_if.wr_data;
                holding = 1'b1;
            end
        end
        if (rx_n < nb && rx_n < stop_after) check_val("timeout_beats", rx_n, nb);
    endtask

    // Full expansion followed by the completion checks
    task automatic full_run(input logic [1:0] mode, input logic [255:0] key, input int ready_mode,
                            input bit dec, output int final_edge);
        build_model(mode, key);
        start_key(mode, key, dec);
        check_val("busy_start", busy, 1'b1);
        check_val("kready_start", key_ready, 1'b0);
        run_sched(ready_mode, 64, final_edge);
        check_val("kready_before", key_ready, 1'b0);
        @(posedge clk);
        #1;
        check_val("kready_done", key_ready, 1'b1);
        check_val("busy_done", busy, 1'b0);
        check_val("beats", rx_n, m_nw / WPB);
    endtask

    initial begin
        logic [255:0] k_a1, k_a2, k_a3, k_r;
        int           fe;
        int           wr_seen;
        logic [1:0]   m_r;

        build_sbox();
        k_a1 = {128'h2b7e1516_28aed2a6_abf71588_09cf4f3c, {4{$urandom}}};
        k_a2 = {192'h8e73b0f7_da0e6452_c810f32b_809079e5_62f8ead2_522c6b7b, {2{$urandom}}};
        k_a3 = 256'h603deb10_15ca71be_2b73aef0_857d7781_1f352c07_3b6108d7_2d9810a3_0914dff4;

        wr_if.wr_ready = 1'b0;
        #12;
        check_val("rst_wr", wr_if.wr, 1'b0);
        check_val("rst_addr", wr_if.wr_addr, 0);
        check_val("rst_data", wr_if.wr_data, 0);
        check_val("rst_busy", busy, 1'b0);
        check_val("rst_kready", key_ready, 1'b0);
        check_val("rst_kerr", key_err, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;

        // FIPS-197 A.1, always ready
        full_run(2'b00, k_a1, 0, 1'b0, fe);
        check_val("a1_edge", fe, 55);
        check_val("a1_beat2", rx[2], 64'ha0fafe17_88542cb1);
        check_val("a1_beat21", rx[21][31:0], 32'hb6630ca6);

        // FIPS-197 A.2, always ready
        full_run(2'b01, k_a2, 0, 1'b0, fe);
        check_val("a2_edge", fe, 61);
        check_val("a2_last", rx[25][31:0], 32'h01002202);

        // FIPS-197 A.3, always ready
        full_run(2'b10, k_a3, 0, 1'b0, fe);
        check_val("a3_edge", fe, 74);
        check_val("a3_last", rx[29][31:0], 32'h706c631e);

        // A.1 with wr_ready toggling every 3 cycles
        full_run(2'b00, k_a1, 1, 1'b0, fe);
        check_val("tog_beat2", rx[2], 64'ha0fafe17_88542cb1);

        // Abort an AES-256 expansion after 5 beats, then run a new one
        build_model(2'b10, k_a3);
        start_key(2'b10, k_a3, 1'b0);
        run_sched(0, 5, fe);
        k_r = {8{$urandom}};
        build_model(2'b10, k_r);
        start_key(2'b10, k_r, 1'b0);
        check_val("abort_wr", wr_if.wr, 1'b0);
        check_val("abort_addr", wr_if.wr_addr, 0);
        run_sched(2, 64, fe);
        @(posedge clk);
        #1;
        check_val("abort_kready", key_ready, 1'b1);
        check_val("abort_beats", rx_n, 30);

        // Illegal mode
        start_key(2'b11, {8{$urandom}}, 1'b0);
        check_val("ill_kerr", key_err, 1'b1);
        check_val("ill_kready", key_ready, 1'b0);
        check_val("ill_busy", busy, 1'b0);
        wr_seen = 0;
        wr_if.wr_ready = 1'b1;
        @(posedge clk);
        #1;
        check_val("ill_kerr_pulse", key_err, 1'b0);
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (wr_if.wr) wr_seen++;
        end
        check_val("ill_nowr", wr_seen, 0);

        // Random keys, modes and back-pressure
        for (int t = 0; t < 4; t++) begin
            m_r = 2'($urandom_range(0, 2));
            k_r = {8{$urandom}};
            full_run(m_r, k_r, 2, 1'b0, fe);
        end

`ifdef KEY_EXP_STREAM_DEC_ORDER_EN
        // Descending addresses: 21 first, 0 last
        full_run(2'b00, k_a1, 0, 1'b1, fe);
        check_val("dec_edge", fe, 55);
        cur_dec = 1'b0;
`endif

        // Reset in the middle of an expansion
        build_model(2'b01, k_a2);
        start_key(2'b01, k_a2, 1'b0);
        run_sched(0, 3, fe);
        #2;
        reset_n = 1'b0;
        #1;
        check_val("mrst_wr", wr_if.wr, 1'b0);
        check_val("mrst_busy", busy, 1'b0);
        check_val("mrst_addr", wr_if.wr_addr, 0);
        @(negedge clk);
        reset_n = 1'b1;
        wr_if.wr_ready = 1'b1;
        wr_seen = 0;
        for (int c = 0; c < 80; c++) begin
            @(negedge clk);
            if (wr_if.wr) wr_seen++;
        end
        check_val("mrst_nowr", wr_seen, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
